// File: rtl/synapse_if.sv
// Handshake bundle between a synapse and its neighbours: the input activation
// stream, the weighted-argument stream and the feedback-error stream.
interface synapse_if;
    logic        inp_stb;
    logic [7:0]  inp_dat;
    logic        inp_rdy;
    logic        arg_stb;
    logic [15:0] arg_dat;
    logic        arg_rdy;
    logic        fbk_stb;
    logic [15:0] fbk_dat;
    logic        fbk_rdy;

    modport master (
        output inp_stb, inp_dat, arg_rdy, fbk_stb, fbk_dat,
        input  inp_rdy, arg_stb, arg_dat, fbk_rdy
    );

    modport slave (
        input  inp_stb, inp_dat, arg_rdy, fbk_stb, fbk_dat,
        output inp_rdy, arg_stb, arg_dat, fbk_rdy
    );
endinterface

// File: rtl/synapse.sv
// Single-input weighted synapse: emits wgt*x as a Q8.8 argument and, when
// training, applies a saturating gradient step from the returned error.
module synapse #(
    parameter logic signed [15:0] INIT = 16'sh0100,
    parameter int unsigned        RATE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    synapse_if.slave    bus,
    output logic [15:0] wgt
);
    typedef enum logic [1:0] {
        S_INP = 2'd0,
        S_ARG = 2'd1,
        S_FBK = 2'd2,
        S_UPD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [15:0]        e_q, e_d;
    logic               arg_stb_q, arg_stb_d;
    logic [15:0]        arg_dat_q, arg_dat_d;
    logic signed [15:0] wgt_q, wgt_d;

    logic signed [24:0] prod_s;
    logic signed [24:0] grad_s;
    logic signed [24:0] step_s;
    logic signed [25:0] sum_s;

    function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
        logic signed [15:0] r;
        if (v > 26'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -26'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    // Datapath: weighted argument and the saturated next weight.
    always_comb begin
        prod_s = $signed({{9{wgt_q[15]}}, wgt_q}) * $signed({17'd0, x_q});
        grad_s = $signed({{9{e_q[15]}}, e_q}) * $signed({17'd0, x_q});
        step_s = grad_s >>> (8 + RATE);
        sum_s  = $signed({step_s[24], step_s}) + $signed({{10{wgt_q[15]}}, wgt_q});
    end

    // Next-state logic; data registers only move in the state that owns them.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        e_d       = e_q;
        arg_stb_d = arg_stb_q;
        arg_dat_d = arg_dat_q;
        wgt_d     = wgt_q;
        case (state_q)
            S_INP: begin
                if (bus.inp_stb) begin
                    x_d     = bus.inp_dat;
                    state_d = S_ARG;
                end else begin
                    state_d = S_INP;
                end
            end
            S_ARG: begin
                if (!arg_stb_q) begin
                    arg_stb_d = 1'b1;
                    arg_dat_d = prod_s[23:8];
                end else if (bus.arg_rdy) begin
                    arg_stb_d = 1'b0;
                    state_d   = en ? S_FBK : S_INP;
                end else begin
                    arg_stb_d = 1'b1;
                end
            end
            S_FBK: begin
                if (bus.fbk_stb) begin
                    e_d     = bus.fbk_dat;
                    state_d = S_UPD;
                end else begin
                    state_d = S_FBK;
                end
            end
            S_UPD: begin
                wgt_d   = sat16(sum_s);
                state_d = S_INP;
            end
            default: begin
                state_d   = S_INP;
                arg_stb_d = 1'b0;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_INP;
            x_q       <= 8'd0;
            e_q       <= 16'd0;
            arg_stb_q <= 1'b0;
            arg_dat_q <= 16'd0;
            wgt_q     <= INIT;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            e_q       <= e_d;
            arg_stb_q <= arg_stb_d;
            arg_dat_q <= arg_dat_d;
            wgt_q     <= wgt_d;
        end
    end

    assign bus.inp_rdy = (state_q == S_INP);
    assign bus.fbk_rdy = (state_q == S_FBK);
    assign bus.arg_stb = arg_stb_q;
    assign bus.arg_dat = arg_dat_q;
    assign wgt         = wgt_q;
endmodule
